// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the round-robin Alu arbiter: opcodes, FSM states,
// and the latched request record.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational Alu. compout is a<b (signed unless unsig);
// overflow flags signed ADD/SUB overflow and is 0 for unsigned operation.
module Alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] aluout,
  input  logic [2:0]  op,
  input  logic        unsig,
  output logic        compout,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    case (op)
      ALU_AND: aluout = a & b;
      ALU_OR:  aluout = a | b;
      ALU_ADD: begin
        aluout   = sum;
        overflow = !unsig && (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_NOR: aluout = ~(a | b);
      ALU_XOR: aluout = a ^ b;
      ALU_SUB: begin
        aluout   = diff;
        overflow = !unsig && (a[31] != b[31]) && (diff[31] != a[31]);
      end
      default: aluout = '0;
    endcase
    compout = unsig ? (a < b) : ($signed(a) < $signed(b));
  end

endmodule

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module alu_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = IDW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Alu among NREQ requesters (IDLE->EXEC->RESP).
// Optional perf counters perf_ops/perf_ovf are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [NREQ-1:0]    req_unsig,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [31:0]        resp_data,
  output logic               resp_compout,
  output logic               resp_overflow
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_ovf
`endif
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  alu_req_t        req_q, req_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_comp_q, resp_comp_d;
  logic            resp_ovf_q, resp_ovf_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            gany;

  logic [31:0]     alu_a, alu_b, alu_out;
  logic [2:0]      alu_op;
  logic            alu_unsig, alu_comp, alu_ovf;

  alu_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Alu sees operands only while executing, so it stays quiet otherwise.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_unsig = 1'b0;
    if (state_q == S_EXEC) begin
      alu_a     = req_q.a;
      alu_b     = req_q.b;
      alu_op    = req_q.op;
      alu_unsig = req_q.unsig;
    end
  end

  Alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .aluout   (alu_out),
    .op       (alu_op),
    .unsig    (alu_unsig),
    .compout  (alu_comp),
    .overflow (alu_ovf)
  );

  assign req_ready = (state_q == S_IDLE) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    req_d        = req_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_comp_d  = resp_comp_q;
    resp_ovf_d   = resp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (gany) begin
          req_d.a     = req_a[32*gidx +: 32];
          req_d.b     = req_b[32*gidx +: 32];
          req_d.op    = req_op[3*gidx +: 3];
          req_d.unsig = req_unsig[gidx];
          id_d        = gidx;
          ptr_d       = gidx;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_data_d  = alu_out;
        resp_comp_d  = alu_comp;
        resp_ovf_d   = alu_ovf;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDW'(NREQ-1);
      req_q        <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_comp_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      req_q        <= req_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_comp_q  <= resp_comp_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_data     = resp_data_q;
  assign resp_compout  = resp_comp_q;
  assign resp_overflow = resp_ovf_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_ovf_q, perf_ovf_d;
  logic        hs;

  assign hs = resp_valid_q && resp_ready;

  always_comb begin
    perf_ops_d = perf_ops_q;
    perf_ovf_d = perf_ovf_q;
    if (hs) begin
      perf_ops_d = perf_ops_q + 32'd1;
      if (resp_ovf_q) perf_ovf_d = perf_ovf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_ovf_q <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_ovf_q <= perf_ovf_d;
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_ovf = perf_ovf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester ops plus hand-written
// round-robin, backpressure, reset-abort and (with ALU_ARB_PERF_EN) counter sequences.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [3*NREQ-1:0]  req_op;
  logic [NREQ-1:0]    req_unsig;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic               resp_compout;
  logic               resp_overflow;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]        perf_ops;
  logic [31:0]        perf_ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .req_unsig     (req_unsig),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_compout  (resp_compout),
    .resp_overflow (resp_overflow)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops      (perf_ops),
    .perf_ovf      (perf_ovf)
`endif
  );

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        u;
    logic [31:0] d;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int rq, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic u);
    req_a[32*rq +: 32] = a;
    req_b[32*rq +: 32] = b;
    req_op[3*rq +: 3]  = op;
    req_unsig[rq]      = u;
  endtask

  // Issue one request alone, then walk it through EXEC and RESP.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    req_valid = '0;
    req_valid[v.rq] = 1'b1;
    set_req(v.rq, v.a, v.b, v.op, v.u);
    #1 check("req_ready grant", 64'(req_ready), 64'd1 << v.rq);
    @(posedge clk);
    #1 req_valid = '0;
    check("resp_valid low in exec", 64'(resp_valid), 64'd0);
    check("req_ready low in exec", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("resp_valid at T+2", 64'(resp_valid), 64'd1);
    check("resp_id", 64'(resp_id), 64'(v.rq));
    check("resp_data", 64'(resp_data), 64'(v.d));
    check("resp_compout", 64'(resp_compout), 64'(v.c));
    check("resp_overflow", 64'(resp_overflow), 64'(v.v));
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("resp_valid drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int n;
    int ids[5];
    int seen;

    vecs[0] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[1] = '{2, 32'h43667107, 32'h0CC64678, 3'b110, 1'b0, 32'h36A02A8F, 1'b0, 1'b0};
    vecs[2] = '{1, 32'h43667107, 32'h0CC64678, 3'b000, 1'b0, 32'h00464000, 1'b0, 1'b0};
    vecs[3] = '{3, 32'hF0F0F0F0, 32'h0F0F0000, 3'b001, 1'b1, 32'hFFFFF0F0, 1'b0, 1'b0};
    vecs[4] = '{0, 32'hFFFF0000, 32'h00FF00FF, 3'b101, 1'b0, 32'hFF0000FF, 1'b1, 1'b0};
    vecs[5] = '{1, 32'h00000000, 32'h00000000, 3'b100, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6] = '{2, 32'h80000000, 32'h00000001, 3'b110, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[7] = '{3, 32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vecs[8] = '{0, 32'h00000005, 32'h00000007, 3'b110, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_unsig = '0;
    resp_ready = 1'b0;
    do_reset();

    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_id", 64'(resp_id), 64'd0);
    check("rst resp_data", 64'(resp_data), 64'd0);
    check("rst resp_compout", 64'(resp_compout), 64'd0);
    check("rst resp_overflow", 64'(resp_overflow), 64'd0);
    check("rst req_ready idle", 64'(req_ready), 64'd0);
    req_valid = 4'b1001;
    #1 check("rst priority req0", 64'(req_ready), 64'b0001);
    req_valid = '0;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // All four requesters contend with a free-running consumer.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h43667107, 32'h0CC64678, 3'b000, 1'b0);
    ids = '{0, 1, 2, 3, 0};
    @(negedge clk);
    req_valid = '1;
    resp_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        check("rr id order", 64'(resp_id), 64'(ids[n]));
        check("rr and data", 64'(resp_data), 64'h00464000);
        check("rr req_ready in resp", 64'(req_ready), 64'd0);
        n++;
      end
    end
    check("rr response count", 64'(n), 64'd5);
    req_valid = '0;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Backpressure: req1 waits while the req0 response is held.
    do_reset();
    @(negedge clk);
    set_req(0, 32'd1, 32'd2, 3'b010, 1'b0);
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    set_req(1, 32'd10, 32'd3, 3'b110, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp resp_valid", 64'(resp_valid), 64'd1);
      check("bp resp_data", 64'(resp_data), 64'd3);
      check("bp resp_id", 64'(resp_id), 64'd0);
      check("bp req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp idle resp_valid", 64'(resp_valid), 64'd0);
    check("bp idle grant req1", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
    check("bp req1 id", 64'(resp_id), 64'd1);
    check("bp req1 data", 64'(resp_data), 64'd7);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Reset while the op is in EXEC must drop it.
    do_reset();
    @(negedge clk);
    set_req(2, 32'd4, 32'd4, 3'b010, 1'b0);
    req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort no response", 64'(seen), 64'd0);
    req_valid = '1;
    #1 check("abort first grant req0", 64'(req_ready), 64'b0001);
    req_valid = '0;

`ifdef ALU_ARB_PERF_EN
    do_reset();
    check("perf_ops after rst", 64'(perf_ops), 64'd0);
    check("perf_ovf after rst", 64'(perf_ovf), 64'd0);
    run_op(vecs[0]);
    run_op(vecs[1]);
    check("perf_ops count", 64'(perf_ops), 64'd2);
    check("perf_ovf count", 64'(perf_ovf), 64'd1);
    do_reset();
    check("perf_ops cleared", 64'(perf_ops), 64'd0);
    check("perf_ovf cleared", 64'(perf_ovf), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
